// File: rtl/spi_param_fifo_pkg.sv
// Shared SPI definitions: bus mode encodings, FIFO size defaults and
// small helpers used by the SPI parameter FIFO.
package spi_param_fifo_pkg;

   typedef enum logic [1:0] {
      SPI_MODE0 = 2'b00,
      SPI_MODE1 = 2'b01,
      SPI_MODE2 = 2'b10,
      SPI_MODE3 = 2'b11
   } spi_mode_e;

   localparam int SPI_MAX_WORD_W  = 32;
   localparam int SPI_FIFO_DATA_W = 8;
   localparam int SPI_FIFO_DEPTH  = 8;

   // Accepted-operation encoding, {write, read}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic bit is_pow2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/spi_param_fifo_mem.sv
// FIFO storage: register array, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module spi_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/spi_param_fifo.sv
// Parameterised synchronous FIFO for the SPI datapath: pointer/count
// bookkeeping, status flags, sticky error flags and registered read data.
module spi_param_fifo
   import spi_param_fifo_pkg::*;
#(
   parameter int DATA_W     = SPI_FIFO_DATA_W,
   parameter int DEPTH      = SPI_FIFO_DEPTH,
   parameter int AFULL_THR  = DEPTH - 1,
   parameter int AEMPTY_THR = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     wr_en_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     rd_en_i,
   output logic [DATA_W-1:0]        rd_data_o,
   output logic                     rd_valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     almost_full_o,
   output logic                     almost_empty_o,
   input  logic                     clr_err_i,
   output logic                     overflow_o,
   output logic                     underflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

   generate
      if (!is_pow2(DEPTH)) begin : g_depth_check
         $error("spi_param_fifo: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] mem_rdata;
   logic              rd_acc;
   logic              wr_acc;
   logic              mem_we;
   fifo_op_e          op;

   // A read frees a slot in the same cycle, which lets a write at full pass through.
   always_comb begin
      rd_acc = rd_en_i && !empty_o;
      wr_acc = wr_en_i && (!full_o || rd_acc);
      op     = fifo_op_e'({wr_acc, rd_acc});
   end

   assign mem_we = wr_acc && !flush_i && !rst;

   assign count_o        = count;
   assign full_o         = (count == DEPTH_C);
   assign empty_o        = (count == '0);
   assign almost_full_o  = (count >= AFULL_C);
   assign almost_empty_o = (count <= AEMPTY_C);

   spi_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr),
      .wdata (wr_data_i),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rd_data_o   <= '0;
         rd_valid_o  <= 1'b0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else if (flush_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rd_valid_o  <= 1'b0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr    <= rd_ptr + 1'b1;
            rd_data_o <= mem_rdata;
         end
         rd_valid_o <= rd_acc;

         case (op)
            OP_PUSH: count <= count + 1'b1;
            OP_POP:  count <= count - 1'b1;
            default: count <= count;
         endcase

         // Set beats clear when both happen in the same cycle.
         overflow_o  <= (wr_en_i && !wr_acc) || (overflow_o && !clr_err_i);
         underflow_o <= (rd_en_i && !rd_acc) || (underflow_o && !clr_err_i);
      end
   end

endmodule

// File: tb/tb_spi_param_fifo.sv
// Directed bench for spi_param_fifo: default instance plus a second
// instance with AFULL_THR=6 / AEMPTY_THR=2 sharing the same stimulus.
module tb_spi_param_fifo;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic       clr_err;

   logic [7:0] rd_data;
   logic       rd_valid;
   logic [3:0] count;
   logic       full, empty, afull, aempty, ovf, unf;

   logic [7:0] t_rd_data;
   logic       t_rd_valid;
   logic [3:0] t_count;
   logic       t_full, t_empty, t_afull, t_aempty, t_ovf, t_unf;

   int checks   = 0;
   int failures = 0;

   spi_param_fifo dut (
      .clk            (clk),
      .rst            (rst),
      .flush_i        (flush),
      .wr_en_i        (wr_en),
      .wr_data_i      (wr_data),
      .rd_en_i        (rd_en),
      .rd_data_o      (rd_data),
      .rd_valid_o     (rd_valid),
      .count_o        (count),
      .full_o         (full),
      .empty_o        (empty),
      .almost_full_o  (afull),
      .almost_empty_o (aempty),
      .clr_err_i      (clr_err),
      .overflow_o     (ovf),
      .underflow_o    (unf)
   );

   spi_param_fifo #(
      .AFULL_THR  (6),
      .AEMPTY_THR (2)
   ) dut_thr (
      .clk            (clk),
      .rst            (rst),
      .flush_i        (flush),
      .wr_en_i        (wr_en),
      .wr_data_i      (wr_data),
      .rd_en_i        (rd_en),
      .rd_data_o      (t_rd_data),
      .rd_valid_o     (t_rd_valid),
      .count_o        (t_count),
      .full_o         (t_full),
      .empty_o        (t_empty),
      .almost_full_o  (t_afull),
      .almost_empty_o (t_aempty),
      .clr_err_i      (clr_err),
      .overflow_o     (t_ovf),
      .underflow_o    (t_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, flush, wr;
      logic [7:0] wd;
      logic       rd, clr;
      logic       valid;
      logic [7:0] data;
      logic [3:0] count;
      logic       full, empty, afull, aempty, ovf, unf;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, sample 1 time unit after the edge, return to idle.
   task automatic step(input logic r, input logic f, input logic w, input logic [7:0] wd,
                       input logic rd, input logic c);
      rst = r; flush = f; wr_en = w; wr_data = wd; rd_en = rd; clr_err = c;
      @(posedge clk);
      #1;
      rst = 0; flush = 0; wr_en = 0; wr_data = 8'h00; rd_en = 0; clr_err = 0;
   endtask

   task automatic push(input logic [7:0] d);
      step(0, 0, 1, d, 0, 0);
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] d);
      step(0, 0, 0, 8'h00, 1, 0);
      chk({tag, "_valid"}, rd_valid, 1'b1);
      chk({tag, "_data"}, rd_data, d);
   endtask

   initial begin
      rst = 0; flush = 0; wr_en = 0; wr_data = 8'h00; rd_en = 0; clr_err = 0;
      //          rst flu wr  wd     rd clr  val data   cnt f  e  af ae ov un
      vecs[0]  = '{1, 0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 1, 0, 1, 0, 0};
      vecs[1]  = '{0, 0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 1, 0, 1, 0, 1};
      vecs[2]  = '{0, 0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 1, 0, 1, 0, 0};
      vecs[3]  = '{0, 0, 1, 8'h01, 1, 0,  0, 8'h00, 1, 0, 0, 0, 1, 0, 1};
      vecs[4]  = '{0, 0, 0, 8'h00, 1, 1,  1, 8'h01, 0, 0, 1, 0, 1, 0, 0};
      vecs[5]  = '{0, 0, 0, 8'h00, 0, 0,  0, 8'h01, 0, 0, 1, 0, 1, 0, 0};
      vecs[6]  = '{0, 0, 1, 8'h11, 0, 0,  0, 8'h01, 1, 0, 0, 0, 1, 0, 0};
      vecs[7]  = '{0, 0, 1, 8'h22, 0, 0,  0, 8'h01, 2, 0, 0, 0, 0, 0, 0};
      vecs[8]  = '{0, 0, 1, 8'h33, 1, 0,  1, 8'h11, 2, 0, 0, 0, 0, 0, 0};
      vecs[9]  = '{0, 1, 1, 8'h44, 1, 0,  0, 8'h11, 0, 0, 1, 0, 1, 0, 0};
      vecs[10] = '{0, 0, 0, 8'h00, 1, 0,  0, 8'h11, 0, 0, 1, 0, 1, 0, 1};
      vecs[11] = '{0, 1, 0, 8'h00, 0, 0,  0, 8'h11, 0, 0, 1, 0, 1, 0, 0};
      vecs[12] = '{0, 0, 1, 8'h55, 0, 0,  0, 8'h11, 1, 0, 0, 0, 1, 0, 0};
      vecs[13] = '{0, 0, 0, 8'h00, 1, 0,  1, 8'h55, 0, 0, 1, 0, 1, 0, 0};

      @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         step(vecs[i].rst, vecs[i].flush, vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
         chk($sformatf("v%0d_valid", i),  rd_valid, vecs[i].valid);
         chk($sformatf("v%0d_data", i),   rd_data,  vecs[i].data);
         chk($sformatf("v%0d_count", i),  count,    vecs[i].count);
         chk($sformatf("v%0d_full", i),   full,     vecs[i].full);
         chk($sformatf("v%0d_empty", i),  empty,    vecs[i].empty);
         chk($sformatf("v%0d_afull", i),  afull,    vecs[i].afull);
         chk($sformatf("v%0d_aempty", i), aempty,   vecs[i].aempty);
         chk($sformatf("v%0d_ovf", i),    ovf,      vecs[i].ovf);
         chk($sformatf("v%0d_unf", i),    unf,      vecs[i].unf);
      end

      // Fill and drain, with both threshold settings observed.
      for (int i = 1; i <= 8; i++) begin
         push(8'(i));
         chk($sformatf("fill%0d_count", i), count, i);
         chk($sformatf("fill%0d_afull", i), afull, (i >= 7));
         chk($sformatf("fill%0d_thr_afull", i), t_afull, (i >= 6));
         chk($sformatf("fill%0d_thr_aempty", i), t_aempty, (i <= 2));
      end
      chk("fill_full", full, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         pop_chk($sformatf("drain%0d", i), 8'(i));
         chk($sformatf("drain%0d_count", i), count, 8 - i);
         chk($sformatf("drain%0d_thr_aempty", i), t_aempty, ((8 - i) <= 2));
      end
      step(0, 0, 0, 8'h00, 0, 0);
      chk("drain_idle_valid", rd_valid, 1'b0);
      chk("drain_empty", empty, 1'b1);

      // Wrap-around across several pointer laps.
      for (int k = 0; k < 20; k++) begin
         push(8'(8'h10 + k));
         chk($sformatf("wrap%0d_count_w", k), count, 1);
         pop_chk($sformatf("wrap%0d", k), 8'(8'h10 + k));
         chk($sformatf("wrap%0d_count_r", k), count, 0);
      end

      // Pass-through at full.
      for (int i = 0; i < 8; i++) push(8'(8'h61 + i));
      step(0, 0, 1, 8'hAA, 1, 0);
      chk("pass_valid", rd_valid, 1'b1);
      chk("pass_data", rd_data, 8'h61);
      chk("pass_count", count, 8);
      chk("pass_ovf", ovf, 1'b0);
      for (int i = 0; i < 7; i++) pop_chk($sformatf("pass_drain%0d", i), 8'(8'h62 + i));
      pop_chk("pass_last", 8'hAA);
      chk("pass_empty", empty, 1'b1);

      // Overflow, clear colliding with a new overflow, then underflow.
      for (int i = 0; i < 8; i++) push(8'(8'h70 + i));
      push(8'h99);
      chk("ovf_set", ovf, 1'b1);
      chk("ovf_count", count, 8);
      step(0, 0, 1, 8'h98, 0, 1);
      chk("ovf_set_wins", ovf, 1'b1);
      step(0, 0, 0, 8'h00, 0, 1);
      chk("ovf_clr", ovf, 1'b0);
      for (int i = 0; i < 8; i++) pop_chk($sformatf("ovf_drain%0d", i), 8'(8'h70 + i));
      step(0, 0, 0, 8'h00, 1, 0);
      chk("unf_set", unf, 1'b1);
      chk("unf_valid", rd_valid, 1'b0);
      chk("unf_data_hold", rd_data, 8'h77);

      // Flush with a concurrent write.
      step(0, 1, 0, 8'h00, 0, 0);
      chk("flush_clr_unf", unf, 1'b0);
      for (int i = 0; i < 5; i++) push(8'(8'h80 + i));
      chk("flush_pre_count", count, 5);
      step(0, 1, 1, 8'hEE, 0, 0);
      chk("flush_count", count, 0);
      chk("flush_empty", empty, 1'b1);
      push(8'h90);
      pop_chk("flush_post", 8'h90);

      // Reset mid-stream overrides everything.
      step(0, 0, 0, 8'h00, 1, 0);
      chk("rst_pre_unf", unf, 1'b1);
      for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
      step(1, 1, 1, 8'hBB, 1, 0);
      chk("rst_count", count, 0);
      chk("rst_data", rd_data, 8'h00);
      chk("rst_valid", rd_valid, 1'b0);
      chk("rst_unf", unf, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_aempty", aempty, 1'b1);
      chk("rst_afull", afull, 1'b0);
      step(0, 0, 0, 8'h00, 1, 0);
      chk("rst_stale_valid", rd_valid, 1'b0);
      chk("rst_stale_data", rd_data, 8'h00);
      push(8'h5A);
      pop_chk("rst_post", 8'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
